fifo: RTL and testbench

FIFO -- requirements
Module: fifo

---
 rtl/fifo.sv | 100 ++++++++++
 tb/tb_fifo.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fifo.sv
// ---------------------------------------------------------------------------
// fifo
//
// Synchronous single-clock FIFO with a registered read port. Storage is a
// DEPTH x WIDTH array addressed by a write pointer and a read pointer. An
// occupancy count (one bit wider than the pointers) drives the full/empty
// flags. A popped word appears on pop_data_o right after the edge that
// accepts the pop, and is held until the next accepted pop.
//
// Parameters
//    WIDTH        data word width in bits
//    DEPTH        number of entries (power of two, >= 2)
//
// Ports
//    clk_i        clock, all state changes on the rising edge
//    rst_i        asynchronous active-high reset
//    push_i       write request
//    push_data_i  write data, sampled when a push is accepted
//    pop_i        read request
//    pop_data_o   registered data from the last accepted pop
//    full_o       high when DEPTH entries are held
//    empty_o      high when no entries are held
// ---------------------------------------------------------------------------
module fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wrPtr;
   logic [AW-1:0]    r_rdPtr;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_popData;

   logic w_full;
   logic w_empty;
   logic w_popAccept;
   logic w_pushAccept;

   // Flags come straight from the registered count, so they change right
   // after the edge that moved the count. A pop is only refused when empty.
   // A push is refused only when full and no pop frees a slot on the same
   // edge, which lets a full FIFO stream one-in/one-out.
   always_comb begin
      w_full       = (r_count == CW'(DEPTH));
      w_empty      = (r_count == '0);
      w_popAccept  = pop_i && !w_empty;
      w_pushAccept = push_i && (!w_full || w_popAccept);
   end

   // Storage array. It has no reset because a slot is never read before it
   // has been written, so its contents after reset are irrelevant.
   always_ff @(posedge clk_i) begin
      if (w_pushAccept) begin
         r_mem[r_wrPtr] <= push_data_i;
      end
   end

   // Pointers, count and the read-data register. DEPTH is a power of two,
   // so letting the pointers overflow naturally gives the modulo-DEPTH wrap.
   // On a simultaneous push and pop the count holds while both pointers move.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wrPtr   <= '0;
         r_rdPtr   <= '0;
         r_count   <= '0;
         r_popData <= '0;
      end else begin
         if (w_pushAccept) begin
            r_wrPtr <= r_wrPtr + AW'(1);
         end
         if (w_popAccept) begin
            r_rdPtr   <= r_rdPtr + AW'(1);
            r_popData <= r_mem[r_rdPtr];
         end
         case ({w_pushAccept, w_popAccept})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign pop_data_o = r_popData;
   assign full_o     = w_full;
   assign empty_o    = w_empty;

endmodule

// File: tb/tb_fifo.sv
// ---------------------------------------------------------------------------
// tb_fifo
//
// Self-checking bench for fifo (WIDTH=32, DEPTH=4). A table of directed
// vectors walks through the basic push/pop, full and empty behaviour, then
// hand-written sequences cover pointer wrap under streaming, push+pop while
// full, and asynchronous reset mid-operation. Finally a random run is
// compared against a queue-based model of the FIFO's behaviour.
// ---------------------------------------------------------------------------
module tb_fifo;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   logic             clk_i;
   logic             rst_i;
   logic             push_i;
   logic [WIDTH-1:0] push_data_i;
   logic             pop_i;
   logic [WIDTH-1:0] pop_data_o;
   logic             full_o;
   logic             empty_o;

   int assertCount;
   int failCount;

   // Reference model: the stored words in push order plus the last popped word.
   logic [WIDTH-1:0] modelQ[$];
   logic [WIDTH-1:0] modelPop;

   typedef struct {
      logic             push;
      logic             pop;
      logic [WIDTH-1:0] data;
      logic [WIDTH-1:0] expData;
      logic             expFull;
      logic             expEmpty;
      string            name;
   } vec_t;

   vec_t vecs[$];

   fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (push_i),
      .push_data_i (push_data_i),
      .pop_i       (pop_i),
      .pop_data_o  (pop_data_o),
      .full_o      (full_o),
      .empty_o     (empty_o)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   function automatic vec_t mkVec(input logic push, input logic pop,
                                  input logic [WIDTH-1:0] data,
                                  input logic [WIDTH-1:0] expData,
                                  input logic expFull, input logic expEmpty,
                                  input string name);
      vec_t v;
      v.push     = push;
      v.pop      = pop;
      v.data     = data;
      v.expData  = expData;
      v.expFull  = expFull;
      v.expEmpty = expEmpty;
      v.name     = name;
      return v;
   endfunction

   // Advance the model by one clock edge using the FIFO's acceptance rules.
   task automatic modelStep(input logic push, input logic pop, input logic [WIDTH-1:0] data);
      bit popOk;
      bit pushOk;
      popOk  = pop && (modelQ.size() > 0);
      pushOk = push && ((modelQ.size() < DEPTH) || popOk);
      if (popOk) modelPop = modelQ.pop_front();
      if (pushOk) modelQ.push_back(data);
   endtask

   // Drive one cycle of inputs, let the edge happen, and settle 1 time unit after it.
   task automatic applyStimulus(input logic push, input logic pop, input logic [WIDTH-1:0] data);
      push_i      = push;
      pop_i       = pop;
      push_data_i = data;
      @(posedge clk_i);
      modelStep(push, pop, data);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [WIDTH-1:0] expData,
                              input logic expFull, input logic expEmpty);
      assertCount++;
      if (pop_data_o !== expData || full_o !== expFull || empty_o !== expEmpty) begin
         failCount++;
         $display("[TB] FAIL %s: got data=%0d full=%b empty=%b, expected data=%0d full=%b empty=%b",
                  name, pop_data_o, full_o, empty_o, expData, expFull, expEmpty);
      end
   endtask

   task automatic checkModel(input string name);
      checkOutput(name, modelPop, modelQ.size() == DEPTH, modelQ.size() == 0);
   endtask

   task automatic doReset();
      rst_i = 1'b1;
      #12;
      rst_i = 1'b0;
      modelQ.delete();
      modelPop = '0;
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      push_i      = 1'b0;
      pop_i       = 1'b0;
      push_data_i = '0;
      modelPop    = '0;
      rst_i       = 1'b0;
      #1;
      doReset();
      @(negedge clk_i);
      checkOutput("reset_state", 0, 1'b0, 1'b1);

      // Directed vectors from a clean reset.
      vecs.push_back(mkVec(0, 1,  0,  0, 0, 1, "pop_when_empty"));
      vecs.push_back(mkVec(1, 0, 10,  0, 0, 0, "push_10"));
      vecs.push_back(mkVec(0, 1,  0, 10, 0, 1, "pop_10"));
      vecs.push_back(mkVec(1, 0, 10, 10, 0, 0, "fill_10"));
      vecs.push_back(mkVec(1, 0, 12, 10, 0, 0, "fill_12"));
      vecs.push_back(mkVec(1, 0, 14, 10, 0, 0, "fill_14"));
      vecs.push_back(mkVec(1, 0, 16, 10, 1, 0, "fill_16_full"));
      vecs.push_back(mkVec(1, 0, 18, 10, 1, 0, "push_18_ignored"));
      vecs.push_back(mkVec(0, 1,  0, 10, 0, 0, "drain_10"));
      vecs.push_back(mkVec(0, 1,  0, 12, 0, 0, "drain_12"));
      vecs.push_back(mkVec(0, 1,  0, 14, 0, 0, "drain_14"));
      vecs.push_back(mkVec(0, 1,  0, 16, 0, 1, "drain_16_empty"));
      vecs.push_back(mkVec(1, 1, 20, 16, 0, 0, "pushpop_while_empty"));
      vecs.push_back(mkVec(0, 1,  0, 20, 0, 1, "pop_20"));
      vecs.push_back(mkVec(0, 1,  0, 20, 0, 1, "pop_empty_holds"));
      vecs.push_back(mkVec(0, 0,  0, 20, 0, 1, "idle_holds"));
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].push, vecs[i].pop, vecs[i].data);
         checkOutput(vecs[i].name, vecs[i].expData, vecs[i].expFull, vecs[i].expEmpty);
      end

      // Streaming across the pointer wrap: three held, push+pop for six cycles.
      for (int i = 1; i <= 3; i++) applyStimulus(1, 0, 32'(100 + i));
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1, 1, 32'(104 + i));
         checkOutput($sformatf("stream_%0d", i), 32'(101 + i), 1'b0, 1'b0);
      end

      // Push and pop together while full: both accepted, stays full.
      applyStimulus(1, 0, 32'd200);
      checkOutput("refill_full", 32'd106, 1'b1, 1'b0);
      applyStimulus(1, 1, 32'd201);
      checkOutput("pushpop_while_full", 32'd107, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 1, 0);
         checkModel($sformatf("drain_after_full_%0d", i));
      end

      // Asynchronous reset with two entries held, checked before any edge.
      applyStimulus(1, 0, 32'd300);
      applyStimulus(1, 0, 32'd301);
      push_i = 1'b0;
      #2;
      rst_i = 1'b1;
      #1;
      checkOutput("async_reset", 0, 1'b0, 1'b1);
      #1;
      rst_i = 1'b0;
      modelQ.delete();
      modelPop = '0;
      @(negedge clk_i);
      applyStimulus(1, 0, 32'd55);
      applyStimulus(1, 0, 32'd66);
      applyStimulus(0, 1, 0);
      checkOutput("first_after_reset", 32'd55, 1'b0, 1'b0);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
         checkModel($sformatf("random_%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
